tcdm_cache_req_scheduler: RTL and testbench
===========================================

Name: tcdm_cache_req_scheduler

Overview:
Shares one OBI/TCDM-style cache port between NR_PORTS requesters, such as FC data, uDMA rx/tx and debug. Selection is round-robin with lock-in. The block tracks up to MAX_OUTSTANDING granted-but-unanswered transactions in an in-order index FIFO, so every rvalid is routed to the requester that issued it. It sits between the requester ports and the data cache's core interface, replacing a single "last granted index" register.

Parameters:
NR_PORTS, 4, number of requester ports (≥2)
MAX_OUTSTANDING, 2, maximum granted transactions awaiting rvalid (≥1)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  NR_PORTS  per-requester request
gnt_o  out  NR_PORTS  per-requester grant
we_i  in  NR_PORTS  per-requester write enable (1 = write)
be_i  in  NR_PORTS x BE_WIDTH  byte enables
addr_i  in  NR_PORTS x ADDR_WIDTH  address
wdata_i  in  NR_PORTS x DATA_WIDTH  write data
rvalid_o  out  NR_PORTS  per-requester response valid
rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters
err_o  out  1  response error, broadcast to all requesters
req_o  out  1  request to cache
gnt_i  in  1  grant from cache
we_o / be_o / addr_o / wdata_o  out  1 / BE_WIDTH / ADDR_WIDTH / DATA_WIDTH  selected request payload
rvalid_i  in  1  response valid from cache
rdata_i  in  DATA_WIDTH  response data from cache
err_i  in  1  response error from cache
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current number of outstanding transactions
protocol_err_o  out  1  sticky flag: rvalid_i received with no outstanding transaction

Behaviour:
- Reset (async, rst_ni=0) state:
  - req_o=0, gnt_o=0, rvalid_o=0, outstanding_o=0, protocol_err_o=0.
  - rr_ptr=0, lock=0, index FIFO empty.
  - Payload outputs = 0.
- Selection:
  - When unlocked, pick the first i with req_i[i]=1, searching from rr_ptr upward modulo NR_PORTS.
  - When locked, sel = locked_idx regardless of other req_i.
- Request gating: req_o = (some requester selected) AND (outstanding < MAX_OUTSTANDING). There is no same-cycle pop bypass, so there is no combinational path from rvalid_i to req_o.
- Payload outputs equal the payload of sel while req_o=1; otherwise they are all zero.
- Lock-in:
  - If req_o=1 and gnt_i=0 at a clock edge, set lock=1 and locked_idx=sel.
  - The lock clears on the edge where gnt_i=1.
  - Requesters must hold req/payload until gnt (OBI rule); the block does not check this.
- Grant: gnt_o[i] = req_o & gnt_i & (sel==i). This is combinational.
- On a handshake (req_o & gnt_i):
  - push sel into the FIFO;
  - rr_ptr <= (sel+1) mod NR_PORTS;
  - lock <= 0.
  - Handshake latency is 0 cycles when the cache grants immediately.
- Response:
  - When rvalid_i=1 and the FIFO is non-empty, rvalid_o[head]=1 in the same cycle (combinational) and the head is popped at the edge.
  - rdata_o=rdata_i and err_o=err_i, passed through unregistered.
- Simultaneous push and pop: outstanding is unchanged, and head/tail both advance (wrap modulo MAX_OUTSTANDING).
- FIFO full: req_o is held at 0, no grants are issued, and lock is unaffected.
- Spurious rvalid (rvalid_i=1 with FIFO empty):
  - all rvalid_o stay 0;
  - protocol_err_o <= 1, and it stays set until reset.
- Responses are strictly in grant order; the cache is in-order.
- Reset mid-operation clears the FIFO and lock. Any pending responses are dropped. Responses arriving after reset are treated as spurious.
- No requests: req_o=0 and rr_ptr is unchanged.

Decomposition:
- Package tcdm_sched_pkg:
  - typedef req_payload_t struct {we, be, addr, wdata};
  - BE_WIDTH/ADDR_WIDTH/DATA_WIDTH localparams.
- Sub-module tcdm_idx_fifo holds the index FIFO (depth MAX_OUTSTANDING, width $clog2(NR_PORTS)). It provides push/pop/full/empty/count and has an async active-low reset.

Test Plan:
1. Single master read: req_i=4'b0001, addr_i[0]=32'h1000, gnt_i=1 → gnt_o=4'b0001 same cycle. Then rvalid_i=1, rdata_i=32'hDEADBEEF → rvalid_o=4'b0001, rdata_o=32'hDEADBEEF, outstanding_o returns to 0.
2. Round-robin: req_i=4'b1011 held, gnt_i=1 each cycle, immediate rvalid → grant order ports 0,1,3,0,1,3.
3. Lock-in: req_i=4'b0100 (port 2) with gnt_i=0 for 3 cycles; port 0 raises req in cycle 1 → addr_o stays port 2 and gnt_o[0]=0. gnt_i=1 in cycle 4 → gnt_o=4'b0100.
4. Outstanding limit (MAX_OUTSTANDING=2): ports 1 and 2 granted, no rvalid → req_o=0 with port 3 requesting, outstanding_o=2. rvalid_i → rvalid_o=4'b0010; the next cycle port 3 is granted. Second rvalid → rvalid_o=4'b0100.
5. Simultaneous push and pop: one transaction outstanding, new grant and rvalid_i in the same cycle → outstanding_o stays 1, and both responses are routed in order.
6. Spurious/reset: rvalid_i=1 when idle → rvalid_o=0, protocol_err_o=1. Then rst_ni low with 2 outstanding → all outputs 0, outstanding_o=0. A later rvalid_i is routed to no port.

Source files
------------

// File: rtl/tcdm_sched_pkg.sv
// Shared types for the TCDM cache request scheduler: default payload widths and the
// per-request payload bundle that is multiplexed onto the cache port.
package tcdm_sched_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_payload_t;

endpackage

// File: rtl/tcdm_idx_fifo.sv
// In-order FIFO of requester indices for granted transactions still awaiting rvalid.
// Push into a full FIFO and pop from an empty one are ignored.
module tcdm_idx_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               cnt_q;
  logic                        do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_cache_req_scheduler.sv
// Round-robin arbiter with lock-in sharing one OBI/TCDM cache port; an index FIFO
// of granted transactions routes each in-order rvalid back to its issuer.
module tcdm_cache_req_scheduler
  import tcdm_sched_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = tcdm_sched_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = tcdm_sched_pkg::DATA_WIDTH,
  parameter int unsigned BE_WIDTH        = tcdm_sched_pkg::BE_WIDTH
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NR_PORTS-1:0]                  req_i,
  output logic [NR_PORTS-1:0]                  gnt_o,
  input  logic [NR_PORTS-1:0]                  we_i,
  input  logic [NR_PORTS-1:0][BE_WIDTH-1:0]    be_i,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  output logic [NR_PORTS-1:0]                  rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic                                 err_o,
  output logic                                 req_o,
  input  logic                                 gnt_i,
  output logic                                 we_o,
  output logic [BE_WIDTH-1:0]                  be_o,
  output logic [ADDR_WIDTH-1:0]                addr_o,
  output logic [DATA_WIDTH-1:0]                wdata_o,
  input  logic                                 rvalid_i,
  input  logic [DATA_WIDTH-1:0]                rdata_i,
  input  logic                                 err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 protocol_err_o
);
  localparam int unsigned IW = $clog2(NR_PORTS);

  logic [IW-1:0] rr_ptr_q, locked_idx_q, sel, head;
  logic          lock_q, sel_vld, hs, pop, full, empty;
  req_payload_t  pl;

  // While locked the pending request is replayed untouched, whatever else is requesting.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (lock_q) begin
      sel     = locked_idx_q;
      sel_vld = 1'b1;
    end else begin
      for (int k = 0; k < NR_PORTS; k++) begin
        if (!sel_vld && req_i[(int'(rr_ptr_q) + k) % NR_PORTS]) begin
          sel     = IW'((int'(rr_ptr_q) + k) % NR_PORTS);
          sel_vld = 1'b1;
        end
      end
    end
  end

  // Gated on FIFO space only; no pop bypass keeps rvalid_i off the req_o path.
  assign req_o = sel_vld & ~full;
  assign hs    = req_o & gnt_i;
  assign pop   = rvalid_i & ~empty;

  always_comb begin
    pl = '0;
    if (req_o) pl = '{we: we_i[sel], be: be_i[sel], addr: addr_i[sel], wdata: wdata_i[sel]};
  end

  assign we_o    = pl.we;
  assign be_o    = pl.be;
  assign addr_o  = pl.addr;
  assign wdata_o = pl.wdata;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (hs)  gnt_o[sel]     = 1'b1;
    if (pop) rvalid_o[head] = 1'b1;
  end

  assign rdata_o = rdata_i;
  assign err_o   = err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q       <= '0;
      lock_q         <= 1'b0;
      locked_idx_q   <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr_q <= (sel == IW'(NR_PORTS-1)) ? '0 : sel + 1'b1;
        lock_q   <= 1'b0;
      end else if (req_o) begin
        lock_q       <= 1'b1;
        locked_idx_q <= sel;
      end
      if (rvalid_i && empty) protocol_err_o <= 1'b1;
    end
  end

  tcdm_idx_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_tcdm_cache_req_scheduler.sv
// Table-driven bench for the cache request scheduler; a queue of expected issuer
// indices checks that every rvalid reaches the port that was granted.
module tb_tcdm_cache_req_scheduler;
  localparam int NP = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NP-1:0]        req_i, gnt_o, we_i, rvalid_o;
  logic [NP-1:0][3:0]   be_i;
  logic [NP-1:0][31:0]  addr_i, wdata_i;
  logic [31:0]          rdata_o, rdata_i, addr_o, wdata_o;
  logic [3:0]           be_o;
  logic                 err_o, req_o, gnt_i, we_o, rvalid_i, err_i, protocol_err_o;
  logic [1:0]           outstanding_o;

  tcdm_cache_req_scheduler #(.NR_PORTS(NP), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o),
    .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o), .rvalid_i(rvalid_i),
    .rdata_i(rdata_i), .err_i(err_i), .outstanding_o(outstanding_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [3:0]  egnt;
    int          eport;  // port expected on the cache side, -1 when req_o must be 0
    logic [1:0]  eout;
  } vec_t;

  vec_t vt[$];
  int   sbq[$];
  int   ntot = 0, npass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic [3:0] req, input logic g, input logic rv,
                              input logic [31:0] rd, input logic [3:0] egnt,
                              input int eport, input logic [1:0] eout);
    vt.push_back('{req, g, rv, rd, egnt, eport, eout});
  endfunction

  task automatic step(input vec_t v);
    logic [3:0]  exp_rv;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        ewe;
    req_i = v.req; gnt_i = v.gnt; rvalid_i = v.rv; rdata_i = v.rdata; err_i = v.rdata[0];
    ea = 0; ew = 0; eb = 0; ewe = 0;
    if (v.eport >= 0) begin
      ea  = 32'h1000 * (v.eport + 1);
      ew  = 32'hC0DE_0000 + v.eport;
      eb  = 4'(v.eport + 1);
      ewe = v.eport[0];
    end
    @(negedge clk_i);
    chk("gnt_o", gnt_o, v.egnt);
    chk("req_o", req_o, v.eport >= 0);
    chk("addr_o", addr_o, ea);
    chk("payload", {we_o, be_o, wdata_o}, {ewe, eb, ew});
    chk("outstanding_o", outstanding_o, v.eout);
    exp_rv = '0;
    if (v.rv) begin
      if (sbq.size() > 0) exp_rv = 4'b1 << sbq.pop_front();
      chk("rdata_o", {err_o, rdata_o}, {v.rdata[0], v.rdata});
    end
    chk("rvalid_o", rvalid_o, exp_rv);
    for (int i = 0; i < NP; i++) if (v.egnt[i]) sbq.push_back(i);
    @(posedge clk_i); #1;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      addr_i[i]  = 32'h1000 * (i + 1);
      wdata_i[i] = 32'hC0DE_0000 + i;
      be_i[i]    = 4'(i + 1);
    end
    we_i = 4'b1010;
    req_i = '0; gnt_i = 0; rvalid_i = 0; rdata_i = '0; err_i = 0;

    // round-robin 0,1,3 twice with rvalid one cycle after each grant
    add(4'b1011, 1, 0, 32'h0,  4'b0001,  0, 0);
    add(4'b1011, 1, 1, 32'h11, 4'b0010,  1, 1);
    add(4'b1011, 1, 1, 32'h22, 4'b1000,  3, 1);
    add(4'b1011, 1, 1, 32'h33, 4'b0001,  0, 1);
    add(4'b1011, 1, 1, 32'h44, 4'b0010,  1, 1);
    add(4'b1011, 1, 1, 32'h55, 4'b1000,  3, 1);
    add(4'b0000, 0, 1, 32'h66, 4'b0000, -1, 1);
    // lock-in on port 2 while port 0 (next in rr order) also requests
    add(4'b0100, 0, 0, 32'h0,  4'b0000,  2, 0);
    add(4'b0101, 0, 0, 32'h0,  4'b0000,  2, 0);
    add(4'b0101, 0, 0, 32'h0,  4'b0000,  2, 0);
    add(4'b0101, 1, 0, 32'h0,  4'b0100,  2, 0);
    add(4'b0000, 0, 1, 32'h77, 4'b0000, -1, 1);
    // single master read
    add(4'b0001, 1, 0, 32'h0,  4'b0001,  0, 0);
    add(4'b0000, 0, 1, 32'hDEADBEEF, 4'b0000, -1, 1);
    add(4'b0000, 0, 0, 32'h0,  4'b0000, -1, 0);
    // outstanding limit: FIFO full blocks port 3 until a response frees a slot
    add(4'b0110, 1, 0, 32'h0,  4'b0010,  1, 0);
    add(4'b1100, 1, 0, 32'h0,  4'b0100,  2, 1);
    add(4'b1000, 1, 0, 32'h0,  4'b0000, -1, 2);
    add(4'b1000, 1, 1, 32'h88, 4'b0000, -1, 2);
    add(4'b1000, 1, 0, 32'h0,  4'b1000,  3, 1);
    add(4'b0000, 0, 1, 32'h99, 4'b0000, -1, 2);
    // simultaneous push and pop
    add(4'b0001, 1, 1, 32'hAA, 4'b0001,  0, 1);
    add(4'b0000, 0, 1, 32'hBB, 4'b0000, -1, 1);
    add(4'b0000, 0, 0, 32'h0,  4'b0000, -1, 0);

    rst_ni = 0;
    #12 rst_ni = 1;
    @(negedge clk_i);
    chk("rst req_o", req_o, 0);
    chk("rst gnt_o", gnt_o, 0);
    chk("rst rvalid_o", rvalid_o, 0);
    chk("rst outstanding_o", outstanding_o, 0);
    chk("rst protocol_err_o", protocol_err_o, 0);
    chk("rst payload", {we_o, be_o, addr_o, wdata_o}, 0);
    @(posedge clk_i); #1;

    foreach (vt[i]) step(vt[i]);
    chk("no protocol_err", protocol_err_o, 0);
    chk("scoreboard drained", sbq.size(), 0);

    // spurious rvalid while idle
    rvalid_i = 1; rdata_i = 32'h5;
    @(negedge clk_i);
    chk("spurious rvalid_o", rvalid_o, 0);
    @(posedge clk_i); #1;
    rvalid_i = 0;
    chk("protocol_err sticky", protocol_err_o, 1);
    @(posedge clk_i); #1;
    chk("protocol_err held", protocol_err_o, 1);

    // two outstanding then reset mid-operation (rr_ptr is 1 here)
    step('{4'b0011, 1, 0, 32'h0, 4'b0010, 1, 0});
    step('{4'b0001, 1, 0, 32'h0, 4'b0001, 0, 1});
    req_i = '0; gnt_i = 0;
    @(negedge clk_i);
    chk("pre-reset outstanding", outstanding_o, 2);
    rst_ni = 0;
    #1;
    chk("mid-rst outstanding", outstanding_o, 0);
    chk("mid-rst outputs", {req_o, gnt_o, rvalid_o, protocol_err_o, addr_o}, 0);
    sbq.delete();
    @(posedge clk_i); #1;
    rst_ni = 1;
    rvalid_i = 1;
    @(negedge clk_i);
    chk("post-rst rvalid_o", rvalid_o, 0);
    @(posedge clk_i); #1;
    rvalid_i = 0;
    chk("post-rst protocol_err", protocol_err_o, 1);
    chk("post-rst outstanding", outstanding_o, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
